// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - shared constants, state encoding and byte helpers for the hash message feeder
//
// Holds the BLAKE3 initial chaining value IV_0..IV_7, block/word geometry,
// the default block budget per message and the feeder state enumeration.
package hash_pkg;

    localparam int BLK_WORDS    = 16;
    localparam int BLK_BYTES    = 64;
    localparam int WIDX_W       = 4;
    localparam int BCNT_W       = 5;
    localparam int BL_W         = 7;
    localparam int MAX_BLKS_DEF = 16;

    localparam logic [31:0] IV_0 = 32'h6A09E667;
    localparam logic [31:0] IV_1 = 32'hBB67AE85;
    localparam logic [31:0] IV_2 = 32'h3C6EF372;
    localparam logic [31:0] IV_3 = 32'hA54FF53A;
    localparam logic [31:0] IV_4 = 32'h510E527F;
    localparam logic [31:0] IV_5 = 32'h9B05688C;
    localparam logic [31:0] IV_6 = 32'h1F83D9AB;
    localparam logic [31:0] IV_7 = 32'h5BE0CD19;

    localparam logic [7:0][31:0] IV = {IV_7, IV_6, IV_5, IV_4, IV_3, IV_2, IV_1, IV_0};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_DRAIN = 3'd5
    } feeder_state_t;

    // Valid byte count of a final word; the 2-bit code 0 stands for a full word.
    function automatic logic [2:0] last_nbytes(input logic [1:0] lb);
        return (lb == 2'd0) ? 3'd4 : {1'b0, lb};
    endfunction

    // Little-endian keep mask for the low nbytes bytes of a word.
    function automatic logic [31:0] byte_mask(input logic [2:0] nbytes);
        case (nbytes)
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            3'd3:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/msg_block_buf.sv
// rtl/msg_block_buf.sv - 16x32 message block buffer with indexed write, byte masking and clear
//
// Ports:
//   clk, rst        clock and synchronous active-high reset (clears the buffer)
//   clr             clear all words to zero (takes priority over a write)
//   wr_en, wr_idx   write enable and word index
//   wr_data         word to store
//   wr_last         word is the final word of the message; apply byte mask
//   wr_last_bytes   valid bytes of the final word (0 means 4)
//   blk_data        whole block, word 0 in blk_data[0]
module msg_block_buf
    import hash_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           wr_en,
    input  logic [WIDX_W-1:0]              wr_idx,
    input  logic [31:0]                    wr_data,
    input  logic                           wr_last,
    input  logic [1:0]                     wr_last_bytes,
    output logic [BLK_WORDS-1:0][31:0]     blk_data
);

    logic [BLK_WORDS-1:0][31:0] words;
    logic [31:0]                wr_masked;

    // Bytes past the end of the message must hash as zero, whatever the source drove.
    always_comb begin
        wr_masked = wr_data;
        if (wr_last) begin
            wr_masked = wr_data & byte_mask(last_nbytes(wr_last_bytes));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            words <= '0;
        end else if (wr_en) begin
            words[wr_idx] <= wr_masked;
        end
    end

    assign blk_data = words;

endmodule

// File: rtl/hash_msg_feeder.sv
// rtl/hash_msg_feeder.sv - packs a word stream into BLAKE3 blocks and sequences HashGen over one chunk
//
// Ports:
//   Clk, Rst                   clock, synchronous active-high reset
//   Data_I, DVld_I, DRdy_O     message word stream (little-endian bytes)
//   Last_I, LastBytes_I        final-word marker and its valid byte count (0 = 4)
//   Strt_O                     one-cycle compression start
//   BL_O, CS/CE/ROOT_flg_O     block length and BLAKE3 flags for the block
//   H_O, Msg_O                 chaining value and message block
//   Vld_I, HRes_I              HashGen done level and result
//   Dgst_O, DgstVld_O          final digest and its one-cycle strobe
//   Err_O                      one-cycle strobe when a message exceeds MAX_BLKS blocks
module hash_msg_feeder
    import hash_pkg::*;
#(
    parameter int MAX_BLKS = MAX_BLKS_DEF
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [31:0]                Data_I,
    input  logic                       DVld_I,
    output logic                       DRdy_O,
    input  logic                       Last_I,
    input  logic [1:0]                 LastBytes_I,
    output logic                       Strt_O,
    output logic [31:0]                BL_O,
    output logic                       CS_flg_O,
    output logic                       CE_flg_O,
    output logic                       ROOT_flg_O,
    output logic [7:0][31:0]           H_O,
    output logic [BLK_WORDS-1:0][31:0] Msg_O,
    input  logic                       Vld_I,
    input  logic [7:0][31:0]           HRes_I,
    output logic [7:0][31:0]           Dgst_O,
    output logic                       DgstVld_O,
    output logic                       Err_O
);

    localparam logic [BCNT_W-1:0] MAX_CNT = BCNT_W'(MAX_BLKS);

    feeder_state_t state, state_nxt;

    logic [WIDX_W-1:0] widx;
    logic [BCNT_W-1:0] blk_cnt;
    logic              first_blk;
    logic              final_blk;
    logic              wait_arm;
    logic [BL_W-1:0]   bl_q;
    logic [7:0][31:0]  h_q;
    logic [7:0][31:0]  dgst_q;
    logic              err_q;

    logic xfer;
    logic overlen;
    logic store;
    logic blk_close;
    logic done_ok;

    assign xfer      = DVld_I & DRdy_O;
    // All permitted blocks have been consumed without seeing the final word.
    assign overlen   = (blk_cnt == MAX_CNT);
    assign store     = xfer && ((state == ST_IDLE) || ((state == ST_FILL) && !overlen));
    assign blk_close = store && (Last_I || (widx == WIDX_W'(BLK_WORDS - 1)));
    // HashGen may still show its previous idle level in the start cycle and the
    // one after it, so Vld_I only counts from the second WAIT cycle on.
    assign done_ok   = (state == ST_WAIT) && wait_arm && Vld_I;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (store) begin
                    state_nxt = blk_close ? ST_START : ST_FILL;
                end
            end
            ST_FILL: begin
                if (xfer) begin
                    if (overlen) begin
                        state_nxt = Last_I ? ST_IDLE : ST_DRAIN;
                    end else if (blk_close) begin
                        state_nxt = ST_START;
                    end
                end
            end
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (done_ok) begin
                    state_nxt = final_blk ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_DRAIN: begin
                if (xfer && Last_I) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        DRdy_O     = 1'b0;
        Strt_O     = 1'b0;
        DgstVld_O  = 1'b0;
        CS_flg_O   = 1'b0;
        CE_flg_O   = 1'b0;
        ROOT_flg_O = 1'b0;
        case (state)
            ST_IDLE, ST_FILL, ST_DRAIN: DRdy_O = !Rst;
            ST_START: begin
                Strt_O     = 1'b1;
                CS_flg_O   = first_blk;
                CE_flg_O   = final_blk;
                ROOT_flg_O = final_blk;
            end
            ST_WAIT: begin
                CS_flg_O   = first_blk;
                CE_flg_O   = final_blk;
                ROOT_flg_O = final_blk;
            end
            ST_DONE:  DgstVld_O = 1'b1;
            default:  DRdy_O = 1'b0;
        endcase
    end

    // Block bookkeeping, chaining value and digest
    always_ff @(posedge Clk) begin
        if (Rst) begin
            widx      <= '0;
            blk_cnt   <= '0;
            first_blk <= 1'b1;
            final_blk <= 1'b0;
            wait_arm  <= 1'b0;
            bl_q      <= '0;
            h_q       <= IV;
            dgst_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            wait_arm <= (state == ST_WAIT);
            err_q    <= (state == ST_FILL) && xfer && overlen;

            if (state == ST_IDLE) begin
                h_q       <= IV;
                first_blk <= 1'b1;
                blk_cnt   <= '0;
                final_blk <= 1'b0;
            end

            if (store) begin
                widx <= widx + 1'b1;
            end
            if (blk_close) begin
                final_blk <= Last_I;
                bl_q      <= Last_I ? ({1'b0, widx, 2'b00} + {4'd0, last_nbytes(LastBytes_I)})
                                    : BL_W'(BLK_BYTES);
            end

            if (done_ok) begin
                widx <= '0;
                if (final_blk) begin
                    dgst_q <= HRes_I;
                end else begin
                    h_q       <= HRes_I;
                    first_blk <= 1'b0;
                    if (blk_cnt != MAX_CNT) begin
                        blk_cnt <= blk_cnt + 1'b1;
                    end
                end
            end
        end
    end

    msg_block_buf u_buf (
        .clk           (Clk),
        .rst           (Rst),
        .clr           (done_ok),
        .wr_en         (store),
        .wr_idx        (widx),
        .wr_data       (Data_I),
        .wr_last       (Last_I),
        .wr_last_bytes (LastBytes_I),
        .blk_data      (Msg_O)
    );

    assign BL_O   = {{(32 - BL_W){1'b0}}, bl_q};
    assign H_O    = h_q;
    assign Dgst_O = dgst_q;
    assign Err_O  = err_q;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// tb/tb_hash_msg_feeder.sv - self-checking bench for hash_msg_feeder with a behavioural BLAKE3 HashGen
module tb_hash_msg_feeder;

    localparam logic [7:0][31:0] IV_B = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                         32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
    localparam logic [7:0][31:0] ABC_DGST = {32'h859dbdd5, 32'h6c9c35fd, 32'h03db795d, 32'h4658c548,
                                             32'hb58d3a27, 32'h753bb6ff, 32'h33514638, 32'hacb33764};

    logic             Clk = 1'b0;
    logic             Rst;
    logic [31:0]      Data_I;
    logic             DVld_I;
    logic             DRdy_O;
    logic             Last_I;
    logic [1:0]       LastBytes_I;
    logic             Strt_O;
    logic [31:0]      BL_O;
    logic             CS_flg_O, CE_flg_O, ROOT_flg_O;
    logic [7:0][31:0] H_O;
    logic [15:0][31:0] Msg_O;
    logic             Vld_I;
    logic [7:0][31:0] HRes_I;
    logic [7:0][31:0] Dgst_O;
    logic             DgstVld_O;
    logic             Err_O;

    hash_msg_feeder #(.MAX_BLKS(16)) dut (
        .Clk(Clk), .Rst(Rst), .Data_I(Data_I), .DVld_I(DVld_I), .DRdy_O(DRdy_O),
        .Last_I(Last_I), .LastBytes_I(LastBytes_I), .Strt_O(Strt_O), .BL_O(BL_O),
        .CS_flg_O(CS_flg_O), .CE_flg_O(CE_flg_O), .ROOT_flg_O(ROOT_flg_O),
        .H_O(H_O), .Msg_O(Msg_O), .Vld_I(Vld_I), .HRes_I(HRes_I),
        .Dgst_O(Dgst_O), .DgstVld_O(DgstVld_O), .Err_O(Err_O)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- BLAKE3 compression model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] w, input int n);
        return (w >> n) | (w << (32 - n));
    endfunction

    function automatic logic [15:0][31:0] gmix(input logic [15:0][31:0] s, input int a, input int b,
                                               input int c, input int d, input logic [31:0] x,
                                               input logic [31:0] y);
        logic [15:0][31:0] v;
        v = s;
        v[a] = v[a] + v[b] + x;
        v[d] = rotr(v[d] ^ v[a], 16);
        v[c] = v[c] + v[d];
        v[b] = rotr(v[b] ^ v[c], 12);
        v[a] = v[a] + v[b] + y;
        v[d] = rotr(v[d] ^ v[a], 8);
        v[c] = v[c] + v[d];
        v[b] = rotr(v[b] ^ v[c], 7);
        return v;
    endfunction

    function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] cv, input logic [15:0][31:0] m_in,
                                                  input logic [31:0] blen, input logic [31:0] flg);
        logic [15:0][31:0] v, m, pm;
        logic [7:0][31:0]  o;
        int perm [16];
        perm = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};
        m = m_in;
        for (int i = 0; i < 8; i++) v[i] = cv[i];
        for (int i = 0; i < 4; i++) v[8 + i] = IV_B[i];
        v[12] = 32'd0;
        v[13] = 32'd0;
        v[14] = blen;
        v[15] = flg;
        for (int r = 0; r < 7; r++) begin
            v = gmix(v, 0, 4,  8, 12, m[0],  m[1]);
            v = gmix(v, 1, 5,  9, 13, m[2],  m[3]);
            v = gmix(v, 2, 6, 10, 14, m[4],  m[5]);
            v = gmix(v, 3, 7, 11, 15, m[6],  m[7]);
            v = gmix(v, 0, 5, 10, 15, m[8],  m[9]);
            v = gmix(v, 1, 6, 11, 12, m[10], m[11]);
            v = gmix(v, 2, 7,  8, 13, m[12], m[13]);
            v = gmix(v, 3, 4,  9, 14, m[14], m[15]);
            for (int i = 0; i < 16; i++) pm[i] = m[perm[i]];
            m = pm;
        end
        for (int i = 0; i < 8; i++) o[i] = v[i] ^ v[i + 8];
        return o;
    endfunction

    logic [7:0] msg_bytes [0:1099];
    logic [7:0] pad_byte;

    // Whole-message digest for a single-chunk message straight from the byte array.
    function automatic logic [7:0][31:0] model_digest(input int nbytes);
        logic [7:0][31:0]  cv;
        logic [15:0][31:0] m;
        int nblk, len, idx;
        logic [31:0] flg;
        cv   = IV_B;
        nblk = (nbytes + 63) / 64;
        for (int b = 0; b < nblk; b++) begin
            m = '0;
            for (int k = 0; k < 64; k++) begin
                idx = 64 * b + k;
                if (idx < nbytes) m[k / 4][8 * (k % 4) +: 8] = msg_bytes[idx];
            end
            len = (b == nblk - 1) ? nbytes - 64 * b : 64;
            flg = ((b == 0) ? 32'd1 : 32'd0) | ((b == nblk - 1) ? 32'd10 : 32'd0);
            cv  = compress(cv, m, 32'(len), flg);
        end
        return cv;
    endfunction

    // ---------------- HashGen model ----------------
    // Vld_I stays high through the start cycle and the one after, and HRes_I keeps
    // the stale previous result until the block really finishes.
    logic             hg_pend, hg_busy;
    int               hg_cnt;
    logic [7:0][31:0] hg_res;

    always @(posedge Clk) begin
        if (Rst) begin
            hg_pend <= 1'b0;
            hg_busy <= 1'b0;
            hg_cnt  <= 0;
            Vld_I   <= 1'b1;
            HRes_I  <= '0;
        end else if (Strt_O) begin
            hg_pend <= 1'b1;
            hg_res  <= compress(H_O, Msg_O, BL_O, {28'd0, ROOT_flg_O, 1'b0, CE_flg_O, CS_flg_O});
        end else if (hg_pend) begin
            hg_pend <= 1'b0;
            hg_busy <= 1'b1;
            Vld_I   <= 1'b0;
            hg_cnt  <= int'($urandom_range(0, 3));
        end else if (hg_busy) begin
            if (hg_cnt == 0) begin
                hg_busy <= 1'b0;
                Vld_I   <= 1'b1;
                HRes_I  <= hg_res;
            end else begin
                hg_cnt <= hg_cnt - 1;
            end
        end
    end

    // ---------------- output monitor ----------------
    int               nstrt = 0, ndgst = 0, nerr = 0;
    logic [31:0]      bl_log [0:255];
    logic [2:0]       fl_log [0:255];
    logic [7:0][31:0] h_log  [0:255];

    always @(negedge Clk) begin
        if (!Rst) begin
            if (Strt_O) begin
                if (nstrt < 256) begin
                    bl_log[nstrt] <= BL_O;
                    fl_log[nstrt] <= {ROOT_flg_O, CE_flg_O, CS_flg_O};
                    h_log[nstrt]  <= H_O;
                end
                nstrt <= nstrt + 1;
            end
            if (DgstVld_O) ndgst <= ndgst + 1;
            if (Err_O)     nerr  <= nerr + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_msg(input int nbytes, input bit with_last, input bit rnd);
        int          nw, guard, idx;
        bit          last, done;
        logic [31:0] w;
        nw = (nbytes + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            last = with_last && (i == nw - 1);
            for (int k = 0; k < 4; k++) begin
                idx = 4 * i + k;
                w[8 * k +: 8] = (idx < nbytes) ? msg_bytes[idx] : pad_byte;
            end
            done  = 1'b0;
            guard = 0;
            while (!done) begin
                @(negedge Clk);
                Data_I      = w;
                Last_I      = last;
                LastBytes_I = last ? 2'(nbytes % 4) : 2'(i);
                DVld_I      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                done = DVld_I && DRdy_O;
                @(posedge Clk);
                guard++;
                if (!done && guard > 200) begin
                    total++;
                    bad++;
                    $display("FAIL send_timeout: word %0d not accepted, got DRdy_O=%0b expected 1", i, DRdy_O);
                    @(negedge Clk);
                    DVld_I = 1'b0;
                    Last_I = 1'b0;
                    return;
                end
            end
        end
        @(negedge Clk);
        DVld_I = 1'b0;
        Last_I = 1'b0;
    endtask

    task automatic wait_end(input int bd, input int be);
        int g;
        g = 0;
        while (ndgst == bd && nerr == be && g < 400) begin
            @(posedge Clk);
            #2;
            g++;
        end
        if (g >= 400) begin
            total++;
            bad++;
            $display("FAIL end_timeout: got no DgstVld_O/Err_O, expected one within 400 cycles");
        end
        repeat (3) @(posedge Clk);
        #2;
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < 1100; k++) msg_bytes[k] = 8'((k * 13 + 5) & 255);
    endtask

    typedef struct {
        int nbytes;
        bit is_abc;
        bit rnd;
        int exp_strt;
        int exp_last_bl;
        int exp_dgst;
        int exp_err;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int bs, bd, be, nb;
        bit lastb;

        vecs[0]  = '{3,    1'b1, 1'b0, 1,  3,  1, 0};
        vecs[1]  = '{4,    1'b0, 1'b0, 1,  4,  1, 0};
        vecs[2]  = '{1,    1'b0, 1'b0, 1,  1,  1, 0};
        vecs[3]  = '{64,   1'b0, 1'b0, 1,  64, 1, 0};
        vecs[4]  = '{65,   1'b0, 1'b0, 2,  1,  1, 0};
        vecs[5]  = '{128,  1'b0, 1'b0, 2,  64, 1, 0};
        vecs[6]  = '{326,  1'b0, 1'b0, 6,  6,  1, 0};
        vecs[7]  = '{326,  1'b0, 1'b1, 6,  6,  1, 0};
        vecs[8]  = '{1024, 1'b0, 1'b0, 16, 64, 1, 0};
        vecs[9]  = '{1028, 1'b0, 1'b0, 16, 64, 0, 1};
        vecs[10] = '{1032, 1'b0, 1'b0, 16, 64, 0, 1};

        pad_byte    = 8'hA5;
        Rst         = 1'b1;
        DVld_I      = 1'b0;
        Data_I      = '0;
        Last_I      = 1'b0;
        LastBytes_I = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_drdy_low", 256'(DRdy_O), 256'(0));
        Rst = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_drdy_high", 256'(DRdy_O), 256'(1));
        chk("rst_strobes", 256'({Strt_O, DgstVld_O, Err_O, CS_flg_O, CE_flg_O, ROOT_flg_O}), 256'(0));
        chk("rst_bl", 256'(BL_O), 256'(0));
        chk("rst_msg_zero", 256'(Msg_O != '0), 256'(0));
        chk("rst_dgst", Dgst_O, 256'(0));
        chk("rst_h_iv", H_O, IV_B);

        for (int v = 0; v < 11; v++) begin
            fill_pattern();
            if (vecs[v].is_abc) begin
                msg_bytes[0] = 8'h61;
                msg_bytes[1] = 8'h62;
                msg_bytes[2] = 8'h63;
            end
            bs = nstrt;
            bd = ndgst;
            be = nerr;
            send_msg(vecs[v].nbytes, 1'b1, vecs[v].rnd);
            wait_end(bd, be);
            chk($sformatf("v%0d_strt_cnt", v), 256'(nstrt - bs), 256'(vecs[v].exp_strt));
            chk($sformatf("v%0d_dgst_cnt", v), 256'(ndgst - bd), 256'(vecs[v].exp_dgst));
            chk($sformatf("v%0d_err_cnt", v), 256'(nerr - be), 256'(vecs[v].exp_err));
            nb = (nstrt - bs < vecs[v].exp_strt) ? nstrt - bs : vecs[v].exp_strt;
            for (int b = 0; b < nb; b++) begin
                lastb = (b == vecs[v].exp_strt - 1) && (vecs[v].exp_err == 0);
                chk($sformatf("v%0d_b%0d_bl", v, b), 256'(bl_log[bs + b]),
                    256'(lastb ? vecs[v].exp_last_bl : 64));
                chk($sformatf("v%0d_b%0d_flags", v, b), 256'(fl_log[bs + b]),
                    256'({lastb, lastb, b == 0}));
            end
            chk($sformatf("v%0d_h0_iv", v), h_log[bs], IV_B);
            if (vecs[v].exp_dgst != 0) begin
                chk($sformatf("v%0d_digest", v), Dgst_O, model_digest(vecs[v].nbytes));
            end
            if (vecs[v].is_abc) begin
                chk("abc_digest_const", Dgst_O, ABC_DGST);
            end
            chk($sformatf("v%0d_idle_drdy", v), 256'(DRdy_O), 256'(1));
        end

        // Reset while block 2 is waiting on HashGen, then a clean "abc".
        fill_pattern();
        bs = nstrt;
        bd = ndgst;
        send_msg(192, 1'b0, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        chk("rstw_strt_cnt", 256'(nstrt - bs), 256'(3));
        Rst = 1'b1;
        @(negedge Clk);
        chk("rstw_drdy_low", 256'(DRdy_O), 256'(0));
        Rst = 1'b0;
        @(negedge Clk);
        chk("rstw_drdy_high", 256'(DRdy_O), 256'(1));
        chk("rstw_strobes", 256'({Strt_O, CS_flg_O, CE_flg_O, ROOT_flg_O}), 256'(0));
        chk("rstw_msg_zero", 256'(Msg_O != '0), 256'(0));
        chk("rstw_h_iv", H_O, IV_B);
        pad_byte     = 8'h00;
        msg_bytes[0] = 8'h61;
        msg_bytes[1] = 8'h62;
        msg_bytes[2] = 8'h63;
        bs = nstrt;
        send_msg(3, 1'b1, 1'b0);
        wait_end(ndgst, nerr);
        chk("rstw_abc_strt", 256'(nstrt - bs), 256'(1));
        chk("rstw_dgst_cnt", 256'(ndgst - bd), 256'(1));
        chk("rstw_abc_bl", 256'(bl_log[bs]), 256'(3));
        chk("rstw_abc_digest", Dgst_O, ABC_DGST);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
